i2c_cmd_queue: RTL and testbench
================================

I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH SHALL default to 4 and set the queue entries (power of two, 2..16).
REQ-003 Parameter TIMEOUT SHALL default to 1023 and set the max cycles allowed per transaction, measured from m_start.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 wr_en  in  1  push request.
REQ-007 wr_addr  in  7  7-bit I2C slave address.
REQ-008 wr_sub  in  8  register sub-address.
REQ-009 wr_data  in  8  write data byte.
REQ-010 full  out  1  queue holds DEPTH entries.
REQ-011 empty  out  1  queue holds 0 entries.
REQ-012 level  out  clog2(DEPTH)+1  current entry count.
REQ-013 m_start  out  1  one-cycle start pulse to the I2C master.
REQ-014 m_addr / m_sub / m_data  out  7/8/8  command presented to the master.
REQ-015 m_ready  in  1  master idle indication.
REQ-016 busy  out  1  a transaction is in flight (state != IDLE).
REQ-017 done  out  1  one-cycle pulse on normal completion.
REQ-018 err_timeout  out  1  one-cycle pulse on timeout abort.
REQ-019 ovf  out  1  sticky flag: a push arrived while full.

Function
REQ-020 Queue SHALL be a circular FIFO of {addr,sub,data}, 23 bits wide, with wrap-around read and write pointers.
REQ-021 A push SHALL occur on a rising edge with wr_en=1 and full=0; level increments.
REQ-022 wr_en=1 while full=1 SHALL discard the data, set ovf, and leave pointers unchanged, even if a pop occurs on the same edge.
REQ-023 Push and pop on the same edge with full=0 SHALL leave level unchanged; empty=1 with wr_en=1 plus a pop request SHALL pop nothing.
REQ-024 The FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-025 IDLE: if empty=0 and m_ready=1, load m_addr/m_sub/m_data from head, pop, clear timer, go to ISSUE; otherwise stay.
REQ-026 ISSUE: m_start=1 for exactly this one cycle; go to WAIT_BUSY.
REQ-027 WAIT_BUSY: m_ready=0 -> WAIT_DONE; else stay.
REQ-028 WAIT_DONE: m_ready=1 -> pulse done, go to IDLE.
REQ-029 Timer SHALL increment each cycle in WAIT_BUSY or WAIT_DONE; reaching TIMEOUT -> pulse err_timeout, go to IDLE; timeout takes priority over completion on the same cycle.
REQ-030 m_addr/m_sub/m_data SHALL hold stable from the load until the next load.
REQ-031 Latency: push into an empty queue with FSM in IDLE and m_ready=1 SHALL raise m_start for the cycle after the second rising edge following the push edge.
REQ-032 Back-to-back commands SHALL be separated by at least one IDLE cycle.
REQ-033 done and err_timeout SHALL never assert in the same cycle.

Reset
REQ-034 reset=0 SHALL immediately clear pointers, level, timer, ovf, m_start, done, err_timeout, and m_addr/m_sub/m_data, and force IDLE; empty=1, full=0.
REQ-035 Reset mid-transaction SHALL abandon the in-flight command and all queued entries without pulsing done or err_timeout.
REQ-036 Deassertion SHALL be synchronised so that the first active edge is uniform for all state.

Verification
REQ-037 Push {0x68,0x20,0x0F}, model m_ready low for 30 cycles -> m_start once with m_addr=0x68, m_sub=0x20, m_data=0x0F; then done pulse, level 0.
REQ-038 Push 5 with DEPTH=4 while m_ready=0 -> full=1, ovf=1, level=4; after release, exactly the first 4 commands issued in order.
REQ-039 Model holds m_ready low forever (master stuck after stop) -> err_timeout exactly 1023 cycles after m_start, next entry then issued.
REQ-040 Push on the same edge as a pop with level=2 -> level stays 2, no data loss.
REQ-041 Assert reset in WAIT_DONE with 3 queued -> empty=1, busy=0, m_start=0, no done pulse.
REQ-042 Model never drops m_ready after m_start -> FSM stays in WAIT_BUSY until timeout, err_timeout=1, done=0.

Source files
------------

// File: rtl/i2c_cmd_queue_if.sv
// Command-queue bus: producer push port, queue status, and the I2C master command handshake.
// The master modport is the user/master side; the slave modport is the queue itself.
interface i2c_cmd_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_sub;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          m_start;
  logic [6:0]    m_addr;
  logic [7:0]    m_sub;
  logic [7:0]    m_data;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          ovf;

  modport master (
    output wr_en, wr_addr, wr_sub, wr_data, m_ready,
    input  full, empty, level, m_start, m_addr, m_sub, m_data, busy, done, err_timeout, ovf
  );

  modport slave (
    input  wr_en, wr_addr, wr_sub, wr_data, m_ready,
    output full, empty, level, m_start, m_addr, m_sub, m_data, busy, done, err_timeout, ovf
  );
endinterface

// File: rtl/i2c_cmd_queue.sv
// Circular FIFO of {addr,sub,data} I2C commands feeding an issue/wait FSM with a per-transaction
// timeout. Reset asserts asynchronously and is released synchronously for all internal state.
module i2c_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic             clk,
  input logic             reset,
  i2c_cmd_queue_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;

  logic [22:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          ovf_q;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          m_start_q;
  logic          done_q;
  logic          err_q;
  logic [6:0]    m_addr_q;
  logic [7:0]    m_sub_q;
  logic [7:0]    m_data_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Assert immediately, release two edges later so every flop leaves reset on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.wr_en && !full;
  assign pop   = (state_q == StIdle) && !empty && bus.m_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.wr_addr, bus.wr_sub, bus.wr_data};
    end
  end

  // A push while full is dropped even when a pop frees a slot on the same edge.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (bus.wr_en && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      m_start_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_addr_q  <= '0;
      m_sub_q   <= '0;
      m_data_q  <= '0;
    end else begin
      m_start_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            {m_addr_q, m_sub_q, m_data_q} <= mem_q[rd_ptr_q];
            timer_q <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          m_start_q <= 1'b1;
          state_q   <= StWaitBusy;
        end
        StWaitBusy, StWaitDone: begin
          timer_q <= timer_q + 1'b1;
          // Timer counts from the m_start cycle; abort wins over a same-cycle completion.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if ((state_q == StWaitBusy) && !bus.m_ready) begin
            state_q <= StWaitDone;
          end else if ((state_q == StWaitDone) && bus.m_ready) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.level       = level_q;
  assign bus.ovf         = ovf_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_sub       = m_sub_q;
  assign bus.m_data      = m_data_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed bench for i2c_cmd_queue: table-driven fill/overflow vectors plus hand-written
// sequences for issue latency, ordering, push/pop collision, timeouts and mid-transaction reset.
module tb_i2c_cmd_queue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 1023;

  typedef enum int {MHold, MNormal, MStuck, MNever} mmode_e;

  typedef struct {
    logic        wr_en;
    logic [22:0] cmd;
    logic [2:0]  exp_level;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          gap_viol = 0;
  bit          idle_seen = 1'b1;
  int          last_start_cyc = 0;
  int          last_err_cyc = 0;
  logic [22:0] cap [$];
  mmode_e      mode = MHold;
  int          low_len = 0;
  int          cnt = 0;
  vec_t        tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_mode(input mmode_e m);
    mode = m;
    cnt  = 0;
  endtask

  // One cycle: sample outputs at the falling edge, then update the master model's m_ready.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.done && bus.err_timeout) both_cnt++;
    if (bus.done) done_cnt++;
    if (bus.err_timeout) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.m_start) begin
      if (!idle_seen) gap_viol++;
      idle_seen = 1'b0;
      cap.push_back({bus.m_addr, bus.m_sub, bus.m_data});
      last_start_cyc = cyc;
    end else if (!bus.busy) begin
      idle_seen = 1'b1;
    end
    case (mode)
      MNormal: begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) bus.m_ready = 1'b1;
        end else if (bus.m_start) begin
          bus.m_ready = 1'b0;
          cnt = low_len;
        end else begin
          bus.m_ready = 1'b1;
        end
      end
      MStuck: begin
        if (bus.m_start) bus.m_ready = 1'b0;
        else if (bus.err_timeout) bus.m_ready = 1'b1;
      end
      MNever: bus.m_ready = 1'b1;
      default: ;
    endcase
  endtask

  task automatic push(input logic [22:0] c);
    bus.wr_en = 1'b1;
    {bus.wr_addr, bus.wr_sub, bus.wr_data} = c;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_m_start", cap.size(), n);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_done", done_cnt, n);
  endtask

  task automatic wait_errs(input int n, input int budget);
    int k = 0;
    while (err_cnt < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_err_timeout", err_cnt, n);
  endtask

  logic [22:0] cmd_a, cmd_b, cmd_c, cmd_d, cmd_e;
  logic [22:0] cmd_x, cmd_y, cmd_z, cmd_p, cmd_q, cmd_r;
  int          db, eb, s0;

  initial begin
    cmd_a = {7'h10, 8'h01, 8'hA1};
    cmd_b = {7'h11, 8'h02, 8'hB2};
    cmd_c = {7'h12, 8'h03, 8'hC3};
    cmd_d = {7'h13, 8'h04, 8'hD4};
    cmd_e = {7'h14, 8'h05, 8'hE5};
    cmd_x = {7'h21, 8'h31, 8'h41};
    cmd_y = {7'h22, 8'h32, 8'h42};
    cmd_z = {7'h23, 8'h33, 8'h43};
    cmd_p = {7'h50, 8'h60, 8'h70};
    cmd_q = {7'h51, 8'h61, 8'h71};
    cmd_r = {7'h3C, 8'h5A, 8'hA5};
    //           wr_en cmd    level full empty ovf
    tbl[0] = '{1'b1, cmd_a, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, cmd_b, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, cmd_c, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, cmd_d, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, cmd_e, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, cmd_a, 3'd4, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_sub = '0;
    bus.wr_data = '0;
    bus.m_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_m_start", 32'(bus.m_start), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_m_cmd", 32'({bus.m_addr, bus.m_sub, bus.m_data}), 32'd0);
    rst_n = 1'b1;
    set_mode(MNormal);
    low_len = 30;
    repeat (4) tick();

    // Single command: latency and contents, then completion.
    bus.wr_en = 1'b1;
    {bus.wr_addr, bus.wr_sub, bus.wr_data} = {7'h68, 8'h20, 8'h0F};
    tick();
    bus.wr_en = 1'b0;
    chk("lat_e0_m_start", 32'(bus.m_start), 32'd0);
    tick();
    chk("lat_e1_m_start", 32'(bus.m_start), 32'd0);
    chk("lat_e1_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("lat_e2_m_start", 32'(bus.m_start), 32'd1);
    chk("cmd_m_addr", 32'(bus.m_addr), 32'h68);
    chk("cmd_m_sub", 32'(bus.m_sub), 32'h20);
    chk("cmd_m_data", 32'(bus.m_data), 32'h0F);
    wait_dones(1, 100);
    chk("single_level", 32'(bus.level), 32'd0);
    chk("single_empty", 32'(bus.empty), 32'd1);
    chk("single_starts", cap.size(), 1);
    chk("single_hold_addr", 32'(bus.m_addr), 32'h68);

    // Fill and overflow with the master holding m_ready low.
    cap.delete();
    set_mode(MHold);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = tbl[i].wr_en;
      {bus.wr_addr, bus.wr_sub, bus.wr_data} = tbl[i].cmd;
      tick();
      chk($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_ovf", i), 32'(bus.ovf), 32'(tbl[i].exp_ovf));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'd0);
    end
    bus.wr_en = 1'b0;
    set_mode(MNormal);
    low_len = 3;
    db = done_cnt;
    wait_starts(4, 200);
    wait_dones(db + 4, 100);
    repeat (10) tick();
    chk("ovf_starts", cap.size(), 4);
    chk("ovf_cmd0", 32'(cap[0]), 32'(cmd_a));
    chk("ovf_cmd1", 32'(cap[1]), 32'(cmd_b));
    chk("ovf_cmd2", 32'(cap[2]), 32'(cmd_c));
    chk("ovf_cmd3", 32'(cap[3]), 32'(cmd_d));
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    chk("ovf_drained", 32'(bus.empty), 32'd1);

    // Push colliding with a pop at level 2.
    cap.delete();
    set_mode(MHold);
    bus.m_ready = 1'b0;
    push(cmd_x);
    push(cmd_y);
    chk("pp_pre_level", 32'(bus.level), 32'd2);
    bus.m_ready = 1'b1;
    push(cmd_z);
    chk("pp_level", 32'(bus.level), 32'd2);
    chk("pp_busy", 32'(bus.busy), 32'd1);
    set_mode(MNormal);
    low_len = 2;
    db = done_cnt;
    wait_starts(3, 300);
    wait_dones(db + 3, 100);
    chk("pp_cmd0", 32'(cap[0]), 32'(cmd_x));
    chk("pp_cmd1", 32'(cap[1]), 32'(cmd_y));
    chk("pp_cmd2", 32'(cap[2]), 32'(cmd_z));

    // Master stuck after m_start: abort, then the next entry is issued.
    cap.delete();
    set_mode(MHold);
    bus.m_ready = 1'b0;
    push(cmd_p);
    push(cmd_q);
    set_mode(MStuck);
    bus.m_ready = 1'b1;
    eb = err_cnt;
    db = done_cnt;
    wait_starts(1, 20);
    s0 = last_start_cyc;
    wait_errs(eb + 1, 1100);
    chk("stuck_timeout_cycles", last_err_cyc - s0, TIMEOUT);
    chk("stuck_cmd0", 32'(cap[0]), 32'(cmd_p));
    wait_starts(2, 20);
    chk("stuck_cmd1", 32'(cap[1]), 32'(cmd_q));
    wait_errs(eb + 2, 1100);
    chk("stuck_no_done", done_cnt, db);

    // Master never drops m_ready: stays busy until the timeout.
    cap.delete();
    set_mode(MNever);
    bus.m_ready = 1'b1;
    eb = err_cnt;
    db = done_cnt;
    push(cmd_r);
    wait_starts(1, 20);
    s0 = last_start_cyc;
    repeat (500) tick();
    chk("never_busy", 32'(bus.busy), 32'd1);
    wait_errs(eb + 1, 1100);
    chk("never_timeout_cycles", last_err_cyc - s0, TIMEOUT);
    chk("never_no_done", done_cnt, db);
    chk("never_cmd", 32'(cap[0]), 32'(cmd_r));

    // Reset while waiting for completion with three entries still queued.
    cap.delete();
    set_mode(MHold);
    bus.m_ready = 1'b0;
    push(cmd_a);
    push(cmd_b);
    push(cmd_c);
    push(cmd_d);
    chk("rq_level4", 32'(bus.level), 32'd4);
    set_mode(MNormal);
    low_len = 1000;
    wait_starts(1, 20);
    repeat (5) tick();
    chk("rq_level3", 32'(bus.level), 32'd3);
    chk("rq_busy", 32'(bus.busy), 32'd1);
    set_mode(MHold);
    db = done_cnt;
    eb = err_cnt;
    rst_n = 1'b0;
    #1;
    chk("rq_empty", 32'(bus.empty), 32'd1);
    chk("rq_busy_clr", 32'(bus.busy), 32'd0);
    chk("rq_m_start", 32'(bus.m_start), 32'd0);
    chk("rq_level0", 32'(bus.level), 32'd0);
    chk("rq_full", 32'(bus.full), 32'd0);
    chk("rq_m_cmd", 32'({bus.m_addr, bus.m_sub, bus.m_data}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus.m_ready = 1'b1;
    repeat (6) tick();
    chk("rq_post_empty", 32'(bus.empty), 32'd1);
    chk("rq_post_busy", 32'(bus.busy), 32'd0);
    chk("rq_no_reissue", cap.size(), 1);
    chk("rq_no_done", done_cnt, db);
    chk("rq_no_err", err_cnt, eb);
    chk("rq_ovf_clr", 32'(bus.ovf), 32'd0);

    chk("done_err_overlap", both_cnt, 0);
    chk("issue_gap", gap_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
